// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner with frame-aligned double-buffered display data.
// Define SEG_HEX_EN to decode nibbles 10..15 as hex glyphs A,b,C,d,E,F.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_v_q, pend_v_d;
    logic                  started_q, started_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic                  cnt_wrap, idx_wrap, frame_edge, guard;
    logic                  keep, blk, sel_dp;
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] blank_mask, an_sel;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b1111110;
            4'd1:    dec7 = 7'b0110000;
            4'd2:    dec7 = 7'b1101101;
            4'd3:    dec7 = 7'b1111001;
            4'd4:    dec7 = 7'b0110011;
            4'd5:    dec7 = 7'b1011011;
            4'd6:    dec7 = 7'b1011111;
            4'd7:    dec7 = 7'b1110000;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1111011;
`ifdef SEG_HEX_EN
            4'd10:   dec7 = 7'b1110111;
            4'd11:   dec7 = 7'b0011111;
            4'd12:   dec7 = 7'b1001110;
            4'd13:   dec7 = 7'b0111101;
            4'd14:   dec7 = 7'b1001111;
            4'd15:   dec7 = 7'b1000111;
`endif
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        cnt_wrap   = (cnt_q == CW'(CLK_DIV - 1));
        idx_wrap   = (idx_q == IW'(NUM_DIGITS - 1));
        frame_edge = cnt_wrap && idx_wrap;
        cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (cnt_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        started_d  = started_q | frame_edge;

        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        if (load) begin
            pend_d    = digits_in;
            pend_dp_d = dp_in;
            pend_v_d  = 1'b1;
        end
        // Display only changes on the last edge of the frame.
        if (frame_edge) begin
            if (load) begin
                disp_d    = digits_in;
                disp_dp_d = dp_in;
            end else if (pend_v_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
            pend_v_d = 1'b0;
        end

        keep       = 1'b0;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (disp_q[4*k +: 4] != 4'd0) keep = 1'b1;
            blank_mask[k] = blank_lz & ~keep;
        end

        nib    = '0;
        sel_dp = 1'b0;
        blk    = 1'b0;
        an_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = disp_q[4*k +: 4];
                sel_dp    = disp_dp_q[k];
                blk       = blank_mask[k];
                an_sel[k] = 1'b1;
            end
        end

        // First cycle of every slot is a dark guard cycle against ghosting.
        guard = (cnt_q == '0);
        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '0;
        if (!guard) begin
            an_d = an_sel;
            if (!blk) seg_d = dec7(nib);
            dp_d = sel_dp & ~blk;
        end
        fd_d = guard && (idx_q == '0) && started_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            disp_dp_q <= '0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            pend_v_q  <= 1'b0;
            started_q <= 1'b0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            an_q      <= '0;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            pend_v_q  <= pend_v_d;
            started_q <= started_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;
endmodule
